// File: rtl/compare_sequencer.sv
// Multi-cycle equality / unsigned-magnitude comparator that walks one CHUNK_SIZE slice per cycle.
// Optional macro COMPARE_SEQUENCER_EARLY_EXIT_EN: finish on the first mismatching chunk.
module compare_sequencer #(
    parameter int unsigned BUS_SIZE   = 32,
    parameter int unsigned CHUNK_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                flush,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                equal,
    output logic                less,
    output logic                busy
);

    localparam int unsigned SAFE_CHUNK = (CHUNK_SIZE == 0) ? 1 : CHUNK_SIZE;
    localparam int unsigned NCHUNK     = BUS_SIZE / SAFE_CHUNK;
    localparam int unsigned IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((CHUNK_SIZE == 0) || ((BUS_SIZE % SAFE_CHUNK) != 0)) begin : gen_cfg_err
        $error("compare_sequencer: BUS_SIZE must be a non-zero multiple of CHUNK_SIZE");
    end

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    state_e              state_q, state_d;
    logic [BUS_SIZE-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                equal_q, equal_d, less_q, less_d;
    logic [BUS_SIZE-1:0] a_shift, b_shift;
    logic [CHUNK_SIZE-1:0] chunk_a, chunk_b;
    logic                mismatch, chunk_lt;

`ifndef COMPARE_SEQUENCER_EARLY_EXIT_EN
    // Sticky record of the first mismatching chunk while the walk continues.
    logic decided_q, decided_d, dec_less_q, dec_less_d;
`endif

    always_comb begin
        a_shift  = a_q >> (32'(idx_q) * CHUNK_SIZE);
        b_shift  = b_q >> (32'(idx_q) * CHUNK_SIZE);
        chunk_a  = a_shift[CHUNK_SIZE-1:0];
        chunk_b  = b_shift[CHUNK_SIZE-1:0];
        mismatch = (chunk_a != chunk_b);
        chunk_lt = (chunk_a < chunk_b);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        equal_d = equal_q;
        less_d  = less_q;
`ifndef COMPARE_SEQUENCER_EARLY_EXIT_EN
        decided_d  = decided_q;
        dec_less_d = dec_less_q;
`endif
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        a_d     = a;
                        b_d     = b;
                        idx_d   = IDX_W'(NCHUNK - 1);
                        state_d = StCompare;
`ifndef COMPARE_SEQUENCER_EARLY_EXIT_EN
                        decided_d  = 1'b0;
                        dec_less_d = 1'b0;
`endif
                    end
                end
                StCompare: begin
`ifdef COMPARE_SEQUENCER_EARLY_EXIT_EN
                    if (mismatch) begin
                        equal_d = 1'b0;
                        less_d  = chunk_lt;
                        state_d = StDone;
                    end else if (idx_q == '0) begin
                        equal_d = 1'b1;
                        less_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
`else
                    if (!decided_q && mismatch) begin
                        decided_d  = 1'b1;
                        dec_less_d = chunk_lt;
                    end
                    if (idx_q == '0) begin
                        equal_d = !(decided_q || mismatch);
                        less_d  = decided_q ? dec_less_q : (mismatch && chunk_lt);
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
`endif
                end
                StDone: begin
                    if (res_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            equal_q <= 1'b0;
            less_q  <= 1'b0;
`ifndef COMPARE_SEQUENCER_EARLY_EXIT_EN
            decided_q  <= 1'b0;
            dec_less_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            equal_q <= equal_d;
            less_q  <= less_d;
`ifndef COMPARE_SEQUENCER_EARLY_EXIT_EN
            decided_q  <= decided_d;
            dec_less_q <= dec_less_d;
`endif
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign res_valid = (state_q == StDone);
    assign equal     = equal_q;
    assign less      = less_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Randomised self-checking bench for compare_sequencer against a behavioural model.
// Honours COMPARE_SEQUENCER_EARLY_EXIT_EN for the expected latency.
module tb_compare_sequencer;

    localparam int unsigned BUS   = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned NCH   = BUS / CHUNK;

    logic           clk = 1'b0;
    logic           rst_n, req_valid, req_ready, flush, res_valid, res_ready;
    logic           equal, less, busy;
    logic [BUS-1:0] a, b;

    int n_checks = 0;
    int n_errors = 0;

    compare_sequencer #(
        .BUS_SIZE   (BUS),
        .CHUNK_SIZE (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .equal     (equal),
        .less      (less),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Chunk (1-based from the MSB) at which the answer is known, from the top differing bit.
    function automatic int exp_latency(input logic [BUS-1:0] x, input logic [BUS-1:0] y);
        logic [BUS-1:0] d;
        int             top;
        d   = x ^ y;
        top = -1;
        for (int i = 0; i < int'(BUS); i++) if (d[i]) top = i;
`ifdef COMPARE_SEQUENCER_EARLY_EXIT_EN
        if (top < 0) return NCH;
        return NCH - top / CHUNK;
`else
        return NCH;
`endif
    endfunction

    // Issue one request from a point between edges; wait for the result, stall, then consume.
    task automatic run_req(input logic [BUS-1:0] x, input logic [BUS-1:0] y, input int stall);
        int lat;
        logic exp_eq, exp_lt;
        exp_eq = (x == y);
        exp_lt = (x < y);
        req_valid = 1'b1;
        a = x;
        b = y;
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_latency(x, y));
        check("equal", equal, exp_eq);
        check("less", less, exp_lt);
        check("busy_done", busy, 1'b1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("bp_res_valid", res_valid, 1'b1);
            check("bp_equal", equal, exp_eq);
            check("bp_less", less, exp_lt);
            check("bp_req_ready", req_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("post_res_valid", res_valid, 1'b0);
        check("post_req_ready", req_ready, 1'b1);
        check("post_equal", equal, exp_eq);
    endtask

    initial begin
        logic [BUS-1:0] x, y, t;
        rst_n = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        flush = 1'b0;
        a = '0;
        b = '0;
        #22;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_equal", equal, 1'b0);
        check("rst_less", less, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_req(32'hDEADBEEF, 32'hDEADBEEF, 0);
        run_req(32'h10FFFFFF, 32'h20000000, 0);
        run_req(32'h12345679, 32'h12345678, 0);
        run_req(32'h00001234, 32'h00001234, 5);

        // flush during the second COMPARE cycle, then accept straight away
        req_valid = 1'b1;
        a = 32'hCAFEF00D;
        b = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_res_valid", res_valid, 1'b0);
        check("fl_req_ready", req_ready, 1'b1);
        check("fl_busy", busy, 1'b0);
        run_req(32'h00000001, 32'h00000002, 0);

        // flush in IDLE blocks a simultaneous request
        flush = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        check("fl_idle_busy", busy, 1'b0);
        check("fl_idle_less", less, 1'b1);

        // asynchronous reset in the middle of a comparison
        req_valid = 1'b1;
        a = 32'h55AA55AA;
        b = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_res_valid", res_valid, 1'b0);
        check("mid_rst_less", less, 1'b0);
        check("mid_rst_equal", equal, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_res_valid", res_valid, 1'b0);
        run_req(32'hFFFFFFFF, 32'h00000000, 1);

        for (int n = 0; n < 60; n++) begin
            x = $urandom;
            t = $urandom;
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ (32'h1 << $urandom_range(0, 31));
                2: y = {x[31:16], t[15:0]};
                default: y = t;
            endcase
            run_req(x, y, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
